// File: rtl/mbscore_int_requester.sv
// mbscore_int_requester: edge-latched, masked, fixed-priority interrupt requester with ack/timeout/gap handshake
module mbscore_int_requester #(
  parameter int NUM_SRC     = 5,
  parameter int SEL_WIDTH   = 3,
  parameter int REQ_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irq_in,
  input  logic [NUM_SRC-1:0]   irq_mask,
  input  logic                 int_ack,
  input  logic                 int_done,
  output logic [SEL_WIDTH-1:0] int_vec,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 busy,
  output logic                 timeout
);
  localparam int TMAX = REQ_TIMEOUT > GAP_CYCLES ? REQ_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) > 0 ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, GAP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cur_q, cur_d, win;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, irq_prev_q, elig, clr;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      timeout_q  <= timeout_d;
    end
  end

  // lowest eligible index wins: scan downward so the last hit is the smallest
  always_comb begin
    elig = pending_q & ~irq_mask;
    win  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win = CW'(i);
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    timer_d   = timer_q == TW'(TMAX - 1) ? timer_q : timer_q + 1'b1;
    timeout_d = 1'b0;
    clr       = '0;
    case (state_q)
      IDLE:
        if (|elig) begin
          state_d = REQ;
          cur_d   = win;
          timer_d = '0;
        end
      REQ:
        if (int_ack) begin
          state_d = SERVICE;
          clr     = NUM_SRC'(1) << cur_q;
        end else if (timer_q == TW'(REQ_TIMEOUT - 1)) begin
          state_d   = GAP;
          timer_d   = '0;
          timeout_d = 1'b1;
        end
      SERVICE:
        if (int_done) begin
          state_d = GAP;
          timer_d = '0;
        end
      GAP:
        if (timer_q == TW'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new rise outranks a same-cycle acknowledge clear
    pending_d = (pending_q & ~clr) | (irq_in & ~irq_prev_q);
  end

  always_comb begin
    int_vec = state_q == REQ ? SEL_WIDTH'(cur_q) + SEL_WIDTH'(1) : '0;
    busy    = state_q == REQ || state_q == SERVICE;
    pending = pending_q;
    timeout = timeout_q;
  end
endmodule

// File: doc/mbscore_int_requester.md
Name: mbscore_int_requester

Overview:
- Peripheral-side interrupt request generator. It sits between the keyboard, mouse, UART, storage and ethernet interrupt lines and the CPU interrupt controller's int_vec input.
- It latches request edges, masks and prioritises them, and drives one encoded interrupt code at a time.
- It holds that code until the CPU acknowledges it, tracks the service window until return, and enforces an idle gap so every new request shows a visible change on int_vec.

Parameters:
- NUM_SRC, 5, number of interrupt sources. Index 0..4 = keyboard, mouse, uart, storage, ethernet.
- SEL_WIDTH, 3, width of int_vec; equals INT_SEL_WIDTH.
- REQ_TIMEOUT, 64, maximum cycles a code is held without acknowledge before it is withdrawn.
- GAP_CYCLES, 2, cycles int_vec is forced to 0 between consecutive requests.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  NUM_SRC  raw per-peripheral request lines, synchronous to clk.
- irq_mask  input  NUM_SRC  1 = source blocked from arbitration; its pending bit still latches.
- int_ack  input  1  one-cycle pulse from the CPU when it takes the interrupt (setINTR).
- int_done  input  1  one-cycle pulse at interrupt return.
- int_vec  output  SEL_WIDTH  encoded request. 0 = none; code = source index + 1 (keyboard 1 ... ethernet 5).
- pending  output  NUM_SRC  latched, not-yet-acknowledged requests.
- busy  output  1  high in REQ and SERVICE.
- timeout  output  1  one-cycle pulse when a request is withdrawn unacknowledged.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - int_vec=0, pending=0, busy=0, timeout=0, timer=0.
  - Edge-detect history register = 0. A line already high at reset release therefore counts as an edge.
- Edge capture:
  - irq_prev is registered from irq_in every cycle.
  - A rise (irq_in & ~irq_prev) sets pending[i] at that edge.
  - Level-held lines do not re-set pending.
- Arbitration:
  - Eligible = pending & ~irq_mask.
  - Lowest index wins, so keyboard has the highest priority.
  - Evaluated only in IDLE.
- States:
  - IDLE:
    - If eligible != 0: cur <= winner, int_vec <= winner+1, timer <= 0, go REQ.
    - Otherwise stay; int_vec=0.
  - REQ:
    - int_vec held constant; timer increments.
    - On int_ack: pending[cur] cleared, int_vec <= 0, go SERVICE.
    - Else if timer == REQ_TIMEOUT-1: int_vec <= 0, timeout=1 for one cycle, pending[cur] kept, go GAP.
    - Masking cur during REQ does not withdraw the request.
  - SERVICE:
    - int_vec=0, busy=1.
    - On int_done go GAP. No other request is issued meanwhile (no nesting).
  - GAP:
    - int_vec=0; counts GAP_CYCLES cycles, then IDLE.
- Latency: irq_in rise first sampled at edge k sets pending at edge k. int_vec = code after edge k+1, provided the FSM was in IDLE and the source is unmasked.
- Simultaneous events:
  - A rise on the source being cleared by int_ack in the same cycle leaves pending[cur]=1 (set wins).
  - int_ack and timeout expiry in the same cycle: ack wins, no timeout pulse.
  - int_ack outside REQ is ignored.
  - int_done outside SERVICE is ignored.
- Widths: the timer is wide enough for REQ_TIMEOUT-1 and saturates; it never wraps.

Test Plan:
- Single source: rst, then uart rise at edge k.
  - pending=5'b00100 at k; int_vec=3 after k+1; busy=1.
  - int_ack: int_vec=0, pending=0.
  - int_done: 2 gap cycles, then IDLE.
- Priority: mouse and ethernet rise on the same cycle.
  - int_vec=2 first.
  - After ack, done and 2-cycle gap: int_vec=5.
- Mask: irq_mask=5'b00001 with keyboard rise.
  - pending[0]=1, int_vec stays 0.
  - Clear mask: int_vec=1 one cycle later.
- Timeout: storage rise, no ack.
  - int_vec=4 for exactly 64 cycles, then timeout pulse, int_vec=0, pending[3] still 1.
  - After the gap, int_vec=4 again.
- Collision: keyboard rise in the same cycle as its int_ack → pending[0]=1 after the ack. Same-cycle ack and timeout expiry → no timeout pulse.
- Reset mid-SERVICE: rst asserted asynchronously → int_vec=0, pending=0, busy=0 immediately, without waiting for a clock edge.
